dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the 5-stage MIPS pipeline. It serves load/store requests issued by the MEM stage and stores data in an internal word array. Each request is answered after a configurable latency, and the block raises a stall to freeze the pipeline until the answer arrives. It replaces the single-cycle data memory so the core can be exercised against realistic memory latency.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_word_array.sv | 33 +++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_MIN_LATENCY = 1;

  // Number of bits needed to index DEPTH_WORDS words.
  function automatic int unsigned dmem_idx_width(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH_WORDS x 32 storage: combinational read, clocked byte-masked write.
// Contents are deliberately not reset.
module dmem_word_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = dmem_idx_width(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_mask
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rd_data = mem[rd_idx];

  // Byte-lane write; wr_mask[0] covers bits 7:0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: latches a load/store,
// answers after LATENCY cycles and stalls the pipeline until then.
// Optional feature macro: DMEM_BYTE_EN (adds req_be and byte-masked stores).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        err_misaligned,
  output logic        mem_stall
);

  localparam int unsigned IDX_W = dmem_idx_width(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             write_q;
  logic [31:0]      rdata_q;
  logic [31:0]      arr_rdata;
  logic [3:0]       wr_mask;
  logic             req_any;
  logic             accept;
  logic             misaligned_q;
  logic             wr_en;
  logic             unused_addr_hi;

  assign req_any        = req_read | req_write;
  assign accept         = (state == IDLE) && req_any;
  assign misaligned_q   = (addr_q[1:0] != 2'b00);
  assign wr_en          = (state == RESP) && write_q && !misaligned_q;
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];

`ifdef DMEM_BYTE_EN
  logic [3:0] be_q;

  // Byte enables travel with the rest of the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      be_q <= '0;
    end else if (accept) begin
      be_q <= req_be;
    end
  end

  assign wr_mask = be_q;
`else
  assign wr_mask = '1;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: IDLE -> BUSY/RESP on a request, BUSY counts down, RESP -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_any) state_next = (LATENCY == DMEM_MIN_LATENCY) ? RESP : BUSY;
      BUSY: if (cnt == CNT_W'(1)) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture and latency countdown; simultaneous read+write is a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      addr_q  <= req_addr[IDX_W+1:0];
      wdata_q <= req_wdata;
      write_q <= req_write;
      cnt     <= CNT_W'(LATENCY - 1);
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Remember the last response data so resp_rdata holds outside RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (state == RESP) begin
      rdata_q <= resp_rdata;
    end
  end

  // Response outputs and handshake.
  always_comb begin
    req_ready      = (state == IDLE);
    resp_valid     = (state == RESP);
    err_misaligned = (state == RESP) && misaligned_q;
    resp_rdata     = rdata_q;
    if (state == RESP) begin
      if (misaligned_q) begin
        resp_rdata = '0;
      end else if (!write_q) begin
        resp_rdata = arr_rdata;
      end
    end
  end

  assign mem_stall = !reset && req_any && !resp_valid;

  dmem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .rd_idx (addr_q[IDX_W+1:2]),
    .rd_data(arr_rdata),
    .wr_en  (wr_en),
    .wr_idx (addr_q[IDX_W+1:2]),
    .wr_data(wdata_q),
    .wr_mask(wr_mask)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance at LATENCY=2 and one at
// LATENCY=1, both 256 words, checked against a word-array reference model.
module tb_dmem_responder;

  logic        clk;
  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ready [2];
  logic        valid [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        stall [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem  [2][256];
  logic [31:0] last_rdata [2];
  int          lat_of     [2];

  dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (2)
  ) u_dut_l2 (
    .clk           (clk),
    .reset         (rst[0]),
    .req_read      (rd[0]),
    .req_write     (wr[0]),
    .req_addr      (addr[0]),
    .req_wdata     (wdata[0]),
`ifdef DMEM_BYTE_EN
    .req_be        (be[0]),
`endif
    .req_ready     (ready[0]),
    .resp_valid    (valid[0]),
    .resp_rdata    (rdata[0]),
    .err_misaligned(err[0]),
    .mem_stall     (stall[0])
  );

  dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (1)
  ) u_dut_l1 (
    .clk           (clk),
    .reset         (rst[1]),
    .req_read      (rd[1]),
    .req_write     (wr[1]),
    .req_addr      (addr[1]),
    .req_wdata     (wdata[1]),
`ifdef DMEM_BYTE_EN
    .req_be        (be[1]),
`endif
    .req_ready     (ready[1]),
    .resp_valid    (valid[1]),
    .resp_rdata    (rdata[1]),
    .err_misaligned(err[1]),
    .mem_stall     (stall[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // One transaction; called at posedge+1, returns at posedge+2 of the cycle
  // after the response, so a following call issues back-to-back.
  task automatic run_req(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] b, input string tag);
    int          cyc;
    bit          got;
    logic        exp_err;
    int unsigned idx;
    logic [31:0] exp_data;
    logic [31:0] mask;
    logic [3:0]  eb;
    exp_err = (a[1:0] != 2'b00);
    idx     = int'(a[9:2]);
`ifdef DMEM_BYTE_EN
    eb = b;
`else
    eb = 4'hF;
`endif
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    #1;
    checks++;
    if (ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready: got %b expected 1", tag, ready[d]);
    end
    checks++;
    if (stall[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_cycle0: got %b expected 1", tag, stall[d]);
    end
    cyc = 0;
    got = 0;
    while (!got && cyc <= 16) begin
      @(negedge clk);
      if (valid[d] === 1'b1) begin
        got = 1;
      end else begin
        checks++;
        if (stall[d] !== 1'b1) begin
          errors++;
          $display("FAIL %s stall_wait: cycle %0d got %b expected 1", tag, cyc, stall[d]);
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s resp_timeout: no resp_valid within %0d cycles, expected %0d", tag, cyc, lat_of[d]);
    end else begin
      if (cyc != lat_of[d]) begin
        errors++;
        $display("FAIL %s latency: got %0d cycles expected %0d", tag, cyc, lat_of[d]);
      end
      checks++;
      if (stall[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s stall_resp: got %b expected 0", tag, stall[d]);
      end
      checks++;
      if (err[d] !== exp_err) begin
        errors++;
        $display("FAIL %s err_misaligned: got %b expected %b", tag, err[d], exp_err);
      end
      if (r && !w) begin
        exp_data = exp_err ? 32'h0 : model_mem[d][idx];
        checks++;
        if (rdata[d] !== exp_data) begin
          errors++;
          $display("FAIL %s rdata: got %h expected %h", tag, rdata[d], exp_data);
        end
      end
    end
    if (exp_err) begin
      last_rdata[d] = 32'h0;
    end else if (w) begin
      mask = {{8{eb[3]}}, {8{eb[2]}}, {8{eb[1]}}, {8{eb[0]}}};
      model_mem[d][idx] = (model_mem[d][idx] & ~mask) | (wd & mask);
    end else begin
      last_rdata[d] = model_mem[d][idx];
    end
    @(posedge clk);
    #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
    #1;
    checks++;
    if (ready[d] !== 1'b1 || valid[d] !== 1'b0 || stall[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s post_idle: ready=%b valid=%b stall=%b expected 1 0 0", tag, ready[d], valid[d], stall[d]);
    end
    checks++;
    if (rdata[d] !== last_rdata[d]) begin
      errors++;
      $display("FAIL %s rdata_hold: got %h expected %h", tag, rdata[d], last_rdata[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      rd[d] = 1'b1; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = 4'hF;
      last_rdata[d] = 32'h0;
    end
    lat_of[0] = 2;
    lat_of[1] = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b1 || valid[d] !== 1'b0 || err[d] !== 1'b0 ||
          rdata[d] !== 32'h0 || stall[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values[%0d]: ready=%b valid=%b err=%b rdata=%h stall=%b expected 1 0 0 00000000 0",
                 d, ready[d], valid[d], err[d], rdata[d], stall[d]);
      end
      rd[d] = 1'b0;
      rst[d] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ready[d] !== 1'b1 || stall[d] !== 1'b0 || valid[d] !== 1'b0) begin
          errors++;
          $display("FAIL idle_hold[%0d]: ready=%b stall=%b valid=%b expected 1 0 0", d, ready[d], stall[d], valid[d]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fill();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin
        run_req(d, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, "fill");
      end
    end
  endtask

  task automatic test_latency2();
    run_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "l2_write");
    run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "l2_read");
    checks++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL l2_read_const: got %h expected deadbeef", rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_req(1, 1'b0, 1'b1, 32'h4, 32'h11111111, 4'hF, "b2b_write");
    run_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, "b2b_read");
    checks++;
    if (rdata[1] !== 32'h11111111) begin
      errors++;
      $display("FAIL b2b_read_const: got %h expected 11111111", rdata[1]);
    end
  endtask

  task automatic test_misaligned();
    run_req(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'hF, "misaligned_read");
    run_req(0, 1'b0, 1'b1, 32'h12, 32'hCAFEF00D, 4'hF, "misaligned_write");
    run_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, "misaligned_untouched");
    checks++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL misaligned_word10: got %h expected deadbeef", rdata[0]);
    end
  endtask

  task automatic test_wrap();
    run_req(0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, "wrap_write");
    run_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, "wrap_read");
    checks++;
    if (rdata[0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL wrap_read_const: got %h expected a5a5a5a5", rdata[0]);
    end
  endtask

  task automatic test_both_high();
    run_req(0, 1'b1, 1'b1, 32'h40, 32'h0BADCAFE, 4'hF, "both_high_write");
    run_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, "both_high_read");
  endtask

  task automatic test_reset_mid();
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678; be[0] = 4'hF;
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    #1;
    checks++;
    if (ready[0] !== 1'b1 || valid[0] !== 1'b0 || stall[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_immediate: ready=%b valid=%b stall=%b rdata=%h expected 1 0 0 00000000",
               ready[0], valid[0], stall[0], rdata[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid[0] !== 1'b0 || stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_held: valid=%b stall=%b expected 0 0", valid[0], stall[0]);
    end
    rst[0] = 1'b0;
    wr[0] = 1'b0;
    last_rdata[0] = 32'h0;
    @(posedge clk);
    #1;
    run_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, "reset_mid_read_old");
  endtask

`ifdef DMEM_BYTE_EN
  task automatic test_byte_en();
    run_req(0, 1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, "be_prefill");
    run_req(0, 1'b0, 1'b1, 32'h8, 32'h00000000, 4'b0101, "be_partial");
    run_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, "be_read");
    checks++;
    if (rdata[0] !== 32'hFF00FF00) begin
      errors++;
      $display("FAIL be_read_const: got %h expected ff00ff00", rdata[0]);
    end
    run_req(0, 1'b0, 1'b1, 32'h8, 32'h12345678, 4'b0000, "be_zero");
    run_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, "be_zero_read");
  endtask
`endif

  task automatic test_random();
    int unsigned kind;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 80; i++) begin
        kind = $urandom_range(0, 3);
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        run_req(d, (kind != 2), (kind >= 2), a, $urandom, 4'($urandom_range(0, 15)), "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_fill();
    test_latency2();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_both_high();
    test_reset_mid();
`ifdef DMEM_BYTE_EN
    test_byte_en();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
